// File: rtl/arb_pkg.sv
// Shared definitions for the time-sliced round-robin arbiter.
//   arb_state_t       : arbiter FSM state (IDLE / GRANT)
//   MAX_N, IDX_W_MAX  : widest requester vector supported and its index width
//   RESET_PTR_BACKOFF : reset places the last-winner pointer this many slots
//                       below N, so requester 0 is searched first
//   onehot_to_idx     : converts a one-hot vector (up to MAX_N bits) to its index
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int MAX_N             = 16;
   localparam int IDX_W_MAX         = 4;
   localparam int RESET_PTR_BACKOFF = 1;

   // OR-ing the positions of all set bits yields the exact index whenever the
   // input is one-hot, and zero for an all-zero input.
   function automatic logic [IDX_W_MAX-1:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
      logic [IDX_W_MAX-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (onehot[i]) begin
            idx = idx | IDX_W_MAX'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
// Scans req starting at start_idx, wrapping modulo N, and reports the first
// set bit.
//   req        : request vector
//   start_idx  : first index searched (must be < N)
//   win_onehot : one-hot winner, zero when nothing requests
//   win_idx    : index of the winner, zero when nothing requests
//   found      : at least one request was seen
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int N = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] start_idx,
   output logic [N-1:0]    win_onehot,
   output logic [ID_W-1:0] win_idx,
   output logic            found
);

   logic [ID_W:0]   pos_sum;
   logic [ID_W-1:0] pos;

   // Walk the N positions in rotated order. The sum carries one extra bit so
   // the wrap works for non-power-of-two N.
   always_comb begin
      win_onehot = '0;
      found      = 1'b0;
      pos_sum    = '0;
      pos        = '0;
      for (int k = 0; k < N; k++) begin
         pos_sum = {1'b0, start_idx} + (ID_W+1)'(k);
         if (pos_sum >= (ID_W+1)'(N)) begin
            pos_sum = pos_sum - (ID_W+1)'(N);
         end
         pos = pos_sum[ID_W-1:0];
         if (!found && req[pos]) begin
            found           = 1'b1;
            win_onehot[pos] = 1'b1;
         end
      end
   end

   assign win_idx = ID_W'(onehot_to_idx(MAX_N'(win_onehot)));

endmodule

// File: rtl/rr_arbiter_timeslice_n.sv
// N-requester round-robin arbiter with a programmable time slice per grant.
//   clk         : clock, all state on the rising edge
//   reset_n     : asynchronous active-low reset
//   req         : request per requester
//   slice_len   : slice length in cycles, sampled when a grant starts (0 acts as 1)
//   grant       : registered one-hot grant, zero when idle
//   grant_id    : registered index of the owner, zero when idle
//   grant_valid : registered, high while a grant is active
//   slice_done  : high in the final cycle of a slice that ran to full length
module rr_arbiter_timeslice_n
   import arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int SLICE_W = 4,
   localparam int ID_W   = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [N-1:0]       req,
   input  logic [SLICE_W-1:0] slice_len,
   output logic [N-1:0]       grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_valid,
   output logic               slice_done
);

   localparam logic [ID_W-1:0] RESET_LAST = ID_W'(N - RESET_PTR_BACKOFF);

   arb_state_t         state, state_nx;
   logic [SLICE_W-1:0] cnt, cnt_nx;
   logic [ID_W-1:0]    last, last_nx;
   logic [N-1:0]       grant_nx;
   logic [ID_W-1:0]    grant_id_nx;
   logic               grant_valid_nx;

   logic [ID_W-1:0]    start_idx;
   logic [N-1:0]       win_onehot;
   logic [ID_W-1:0]    win_idx;
   logic               found;
   logic               owner_req;
   logic               rearb;
   logic [SLICE_W-1:0] slice_load;

   // Searching from the slot after the last winner puts the current owner
   // (which is always the last winner) at the very end of the order.
   assign start_idx  = (last == ID_W'(N-1)) ? '0 : last + 1'b1;
   assign owner_req  = |(req & grant);
   assign slice_load = (slice_len == '0) ? '0 : slice_len - 1'b1;

   rr_priority_pick #(.N(N)) u_pick (
      .req        (req),
      .start_idx  (start_idx),
      .win_onehot (win_onehot),
      .win_idx    (win_idx),
      .found      (found)
   );

   // State and registered outputs; reset drops any grant immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         cnt         <= '0;
         last        <= RESET_LAST;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         last        <= last_nx;
         grant       <= grant_nx;
         grant_id    <= grant_id_nx;
         grant_valid <= grant_valid_nx;
      end
   end

   // Next-state logic. Arbitration happens when idle, when the owner lets go,
   // or when the slice counter has reached zero; release and expiry share the
   // same path, so a release in the final cycle behaves like any release.
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      last_nx        = last;
      grant_nx       = grant;
      grant_id_nx    = grant_id;
      grant_valid_nx = grant_valid;
      unique case (state)
         IDLE:    rearb = 1'b1;
         GRANT:   rearb = !owner_req || (cnt == '0);
         default: rearb = 1'b1;
      endcase
      if (rearb) begin
         if (found) begin
            state_nx       = GRANT;
            cnt_nx         = slice_load;
            last_nx        = win_idx;
            grant_nx       = win_onehot;
            grant_id_nx    = win_idx;
            grant_valid_nx = 1'b1;
         end else begin
            state_nx       = IDLE;
            cnt_nx         = '0;
            grant_nx       = '0;
            grant_id_nx    = '0;
            grant_valid_nx = 1'b0;
         end
      end else begin
         cnt_nx = cnt - 1'b1;
      end
   end

   // The final cycle of a slice is known from registered state; it only counts
   // as a completed slice if the owner is still requesting in that cycle.
   always_comb begin
      slice_done = (state == GRANT) && (cnt == '0) && owner_req;
   end

endmodule
